// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - stack-port initiator: one high-level stack op at a time
module stack_seq #(
   parameter logic [15:0] SP_INIT     = 16'hffff,
   parameter logic [15:0] STACK_LIMIT = 16'hbfff
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [1:0]  op_code,
   input  logic [15:0] op_data,
   output logic        op_ready,
   output logic        done,
   output logic        err,
   output logic [15:0] result,
   output logic [15:0] sp,
   output logic        mem_push,
   output logic        mem_pop,
   output logic        mem_swap,
   output logic        mem_replace_sp,
   output logic [15:0] mem_data,
   input  logic [15:0] mem_out
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_ISSUE, S_CAPTURE} state_t;

   localparam logic [1:0] OP_PUSH = 2'd0;
   localparam logic [1:0] OP_POP  = 2'd1;
   localparam logic [1:0] OP_XCHG = 2'd2;
   localparam logic [1:0] OP_LDSP = 2'd3;

   state_t      state_q, state_d;
   logic [15:0] sp_q;
   logic [15:0] result_q;
   logic        done_q;
   logic        err_q;
   logic [1:0]  code_q;
   logic [15:0] data_q;
   logic        fail_q;
   logic        fail_d;
   logic [16:0] push_sp;
   logic        accept;

   assign accept  = (state_q == S_IDLE) && op_valid;
   // 17-bit difference so a wrap below zero shows up in bit 16
   assign push_sp = {1'b0, sp_q} - 17'd2;

   // Legality of the requested op against the current shadow SP
   always_comb begin
      fail_d = 1'b0;
      case (op_code)
         OP_PUSH: fail_d = push_sp[16] || (push_sp[15:0] < STACK_LIMIT);
         OP_POP,
         OP_XCHG: fail_d = sp_q > (SP_INIT - 16'd2);
         default: fail_d = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   // Next-state logic: INIT once, then IDLE -> ISSUE -> CAPTURE -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:    state_d = S_IDLE;
         S_IDLE:    if (op_valid) state_d = S_ISSUE;
         S_ISSUE:   state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_IDLE;
         default:   state_d = S_INIT;
      endcase
   end

   // Outputs: strobes only in INIT/ISSUE, forced low while reset is held
   always_comb begin
      op_ready       = (state_q == S_IDLE);
      mem_push       = 1'b0;
      mem_pop        = 1'b0;
      mem_swap       = 1'b0;
      mem_replace_sp = 1'b0;
      mem_data       = SP_INIT;
      if (!reset) begin
         if (state_q == S_INIT) begin
            mem_replace_sp = 1'b1;
         end else if (state_q == S_ISSUE) begin
            mem_data = data_q;
            if (!fail_q) begin
               mem_push       = (code_q == OP_PUSH);
               mem_pop        = (code_q == OP_POP);
               mem_swap       = (code_q == OP_XCHG);
               mem_replace_sp = (code_q == OP_LDSP);
            end
         end
      end
   end

   // Op latch at accept, shadow SP update in ISSUE, completion in CAPTURE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q     <= SP_INIT;
         result_q <= 16'h0000;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= OP_PUSH;
         data_q   <= 16'h0000;
         fail_q   <= 1'b0;
      end else begin
         done_q <= (state_q == S_CAPTURE);
         err_q  <= (state_q == S_CAPTURE) && fail_q;
         if (accept) begin
            code_q <= op_code;
            data_q <= op_data;
            fail_q <= fail_d;
         end
         if (state_q == S_ISSUE && !fail_q) begin
            case (code_q)
               OP_PUSH: sp_q <= sp_q - 16'd2;
               OP_POP:  sp_q <= sp_q + 16'd2;
               OP_LDSP: sp_q <= data_q;
               default: sp_q <= sp_q;
            endcase
         end
         if (state_q == S_CAPTURE && !fail_q &&
             (code_q == OP_POP || code_q == OP_XCHG)) begin
            result_q <= mem_out;
         end
      end
   end

   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;
   assign sp     = sp_q;

endmodule

// File: tb/tb_stack_seq.sv
// tb/tb_stack_seq.sv - self-checking bench for stack_seq
module tb_stack_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [1:0]  op_code;
   logic [15:0] op_data;
   logic        op_ready;
   logic        done;
   logic        err;
   logic [15:0] result;
   logic [15:0] sp;
   logic        mem_push;
   logic        mem_pop;
   logic        mem_swap;
   logic        mem_replace_sp;
   logic [15:0] mem_data;
   logic [15:0] mem_out = 16'h0000;

   int errors = 0;
   int checks = 0;

   stack_seq dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_data(op_data), .op_ready(op_ready), .done(done), .err(err),
      .result(result), .sp(sp), .mem_push(mem_push), .mem_pop(mem_pop),
      .mem_swap(mem_swap), .mem_replace_sp(mem_replace_sp),
      .mem_data(mem_data), .mem_out(mem_out)
   );

   always #5 clk = ~clk;

   // Stand-in for the memory block's stack port
   logic [15:0] tmem [0:65535];
   logic [15:0] msp = 16'h0000;
   logic        tmem_ok = 1'b0;

   always @(posedge clk) begin
      if (!tmem_ok) begin
         for (int i = 0; i < 65536; i++) tmem[i] <= 16'h0000;
         tmem_ok <= 1'b1;
      end else if (mem_push) begin
         tmem[msp - 16'd2] <= mem_data;
         msp <= msp - 16'd2;
      end else if (mem_pop) begin
         mem_out <= tmem[msp];
         msp <= msp + 16'd2;
      end else if (mem_swap) begin
         mem_out <= tmem[msp];
         tmem[msp] <= mem_data;
      end else if (mem_replace_sp) begin
         msp <= mem_data;
      end
   end

   // Op-level reference: a word-addressed stack image plus a shadow SP
   logic [15:0] ref_mem [0:65535];
   int          ref_sp;
   logic [15:0] exp_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] strobes();
      return {mem_push, mem_pop, mem_swap, mem_replace_sp};
   endfunction

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("init_strobe", {28'd0, strobes()}, 32'h1);
      chk("init_data", {16'd0, mem_data}, 32'hffff);
      chk("init_ready", {31'd0, op_ready}, 32'd0);
      chk("init_sp", {16'd0, sp}, 32'hffff);
      chk("init_result", {16'd0, result}, 32'h0);
      chk("init_done", {30'd0, done, err}, 32'd0);
      @(negedge clk);
      chk("idle_ready", {31'd0, op_ready}, 32'd1);
      chk("idle_strobe", {28'd0, strobes()}, 32'h0);
      ref_sp  = 32'hffff;
      exp_res = 16'h0000;
   endtask

   task automatic do_op(input logic [1:0] code, input logic [15:0] data);
      int          n;
      logic        e;
      logic [3:0]  exp_strb;
      n = 0;
      while (!op_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", {31'd0, op_ready}, 32'd1);
      op_valid = 1'b1;
      op_code  = code;
      op_data  = data;
      @(posedge clk);
      e = 1'b0;
      exp_strb = 4'b0000;
      case (code)
         2'd0: begin
            e = (ref_sp - 2) < 32'hbfff;
            exp_strb = 4'b1000;
            if (!e) begin
               ref_sp = ref_sp - 2;
               ref_mem[ref_sp] = data;
            end
         end
         2'd1: begin
            e = ref_sp > 32'hfffd;
            exp_strb = 4'b0100;
            if (!e) begin
               exp_res = ref_mem[ref_sp];
               ref_sp = (ref_sp + 2) % 65536;
            end
         end
         2'd2: begin
            e = ref_sp > 32'hfffd;
            exp_strb = 4'b0010;
            if (!e) begin
               exp_res = ref_mem[ref_sp];
               ref_mem[ref_sp] = data;
            end
         end
         default: begin
            exp_strb = 4'b0001;
            ref_sp = data;
         end
      endcase
      if (e) exp_strb = 4'b0000;
      @(negedge clk);
      op_valid = 1'b0;
      op_code  = 2'($urandom);
      op_data  = 16'($urandom);
      chk("issue_strobe", {28'd0, strobes()}, {28'd0, exp_strb});
      chk("issue_data", {16'd0, mem_data}, {16'd0, data});
      chk("issue_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("capture_strobe", {28'd0, strobes()}, 32'h0);
      chk("capture_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("done", {31'd0, done}, 32'd1);
      chk("err", {31'd0, err}, {31'd0, e});
      chk("result", {16'd0, result}, {16'd0, exp_res});
      chk("sp", {16'd0, sp}, ref_sp);
      chk("done_ready", {31'd0, op_ready}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0000;
      reset    = 1'b1;
      op_valid = 1'b0;
      op_code  = 2'd0;
      op_data  = 16'h0000;
      repeat (3) @(negedge clk);
      chk("reset_strobe", {28'd0, strobes()}, 32'h0);
      chk("reset_data", {16'd0, mem_data}, 32'hffff);
      release_reset();

      do_op(2'd0, 16'h1234);
      do_op(2'd1, 16'h0000);
      do_op(2'd1, 16'h0000);
      do_op(2'd0, 16'haaaa);
      do_op(2'd2, 16'h5555);
      do_op(2'd1, 16'h0000);
      do_op(2'd3, 16'hc000);
      do_op(2'd0, 16'h7777);
      do_op(2'd3, 16'hc001);
      do_op(2'd0, 16'h8888);
      do_op(2'd3, 16'hffff);

      // Reset in the ISSUE cycle of a PUSH abandons it
      op_valid = 1'b1;
      op_code  = 2'd0;
      op_data  = 16'h4321;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
      chk("abort_push_before", {31'd0, mem_push}, 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_push_drop", {28'd0, strobes()}, 32'h0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      chk("abort_sp", {16'd0, sp}, 32'hffff);
      release_reset();

      for (int k = 0; k < 60; k++) begin
         logic [1:0]  c;
         logic [15:0] d;
         c = 2'($urandom_range(0, 3));
         d = 16'($urandom);
         if (c == 2'd3) begin
            case ($urandom_range(0, 3))
               0: d = 16'hffff;
               1: d = 16'hc001;
               2: d = 16'hc002 + 16'($urandom_range(0, 8));
               default: d = 16'hfff0 + 16'($urandom_range(0, 15));
            endcase
         end
         do_op(c, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- CPU-side initiator for the memory block's stack port.
- Accepts one high-level stack op at a time (PUSH, POP, XCHG, LOAD_SP) over a valid/ready handshake.
- Drives single-cycle push/pop/swap/replace_SP strobes and captures the registered memory output.
- Keeps a shadow SP that mirrors the memory's stack pointer, and checks overflow/underflow before issuing, so the memory never receives an illegal strobe.

Parameters:
SP_INIT, 16'hffff, stack pointer value after reset (empty stack)
STACK_LIMIT, 16'hbfff, lowest legal SP; a push leaving SP below this is an overflow

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
op_valid  input  1  op request
op_code  input  2  0=PUSH, 1=POP, 2=XCHG, 3=LOAD_SP
op_data  input  16  PUSH/XCHG word, or new SP for LOAD_SP
op_ready  output  1  high only in IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = op rejected (overflow/underflow)
result  output  16  POP/XCHG old top-of-stack word; held until next done
sp  output  16  shadow stack pointer
mem_push  output  1  to memory push
mem_pop  output  1  to memory pop
mem_swap  output  1  to memory swap
mem_replace_sp  output  1  to memory replace_SP
mem_data  output  16  to memory input_data
mem_out  input  16  from memory out; valid the cycle after pop/swap strobe

Behaviour:
- Reset (async):
  - state=INIT; sp=SP_INIT; result=0; done=0; err=0.
  - All strobes drop immediately; mem_data=SP_INIT.
  - Reset mid-op abandons the op; no done is produced.
- FSM states: INIT, IDLE, ISSUE, CAPTURE.
- INIT:
  - mem_replace_sp=1, mem_data=SP_INIT for exactly one cycle, which resyncs the memory SP.
  - Then IDLE. op_ready=0.
- IDLE:
  - op_ready=1.
  - On op_valid&&op_ready at edge E0: latch op_code/op_data and compute the error flag, then go to ISSUE.
- Error rules, evaluated at accept against the current sp:
  - PUSH: error if sp-2 < STACK_LIMIT (unsigned, 16-bit wrap counts as error).
  - POP/XCHG: error if sp > SP_INIT-2 (fewer than 2 bytes on stack).
  - LOAD_SP: never errors.
- ISSUE (one cycle):
  - Exactly one strobe high, unless error, in which case none: PUSH→mem_push, POP→mem_pop, XCHG→mem_swap, LOAD_SP→mem_replace_sp.
  - mem_data = latched op_data for the whole cycle.
  - At E1: sp updates. PUSH sp-2, POP sp+2, XCHG unchanged, LOAD_SP op_data, error unchanged.
  - Then CAPTURE.
- CAPTURE (one cycle):
  - All strobes low.
  - At E2: done<=1 and err<=error flag.
  - For non-error POP/XCHG: result<=mem_out. Otherwise result holds.
  - Then IDLE.
- Timing:
  - done is high during the cycle after E2, i.e. latency 3 cycles from accept.
  - The next accept is possible in that same cycle. Throughput is 1 op per 3 cycles.
- Strobes are mutually exclusive and never high outside ISSUE/INIT.
- sp arithmetic is 16-bit modulo. No op is issued whose error flag is set.
- op_data/op_code changes after accept have no effect.

Test Plan:
- Reset release → one cycle mem_replace_sp=1 with mem_data=16'hffff; op_ready rises the next cycle; sp=16'hffff.
- PUSH 16'h1234 → mem_push high exactly 1 cycle with mem_data=16'h1234; done 3 cycles after accept, err=0, sp=16'hfffd.
- Then POP → mem_pop 1 cycle; done with result=16'h1234, err=0, sp=16'hffff. A further POP gives done, err=1, no strobe, sp unchanged.
- PUSH 16'hAAAA, then XCHG 16'h5555 → mem_swap 1 cycle; result=16'hAAAA; sp=16'hfffd. A following POP returns 16'h5555.
- LOAD_SP 16'hc000, then PUSH → err=0, sp=16'hbffe? No: 16'hbffe<16'hbfff gives err=1, no mem_push, sp stays 16'hc000. LOAD_SP 16'hc001, then PUSH → err=0, sp=16'hbfff.
- Assert reset during ISSUE of a PUSH → mem_push drops at once, no done, sp=16'hffff; INIT replace_SP pulse is seen after release.
